// File: rtl/adc_capture_if.sv
// adc_capture_if: ADC sample, register and streaming-output bus of adc_capture_core
interface adc_capture_if #(parameter int DATA_W = 18);
  logic [DATA_W-1:0] adc_din;
  logic adc_din_valid;
  logic reg_wr_en;
  logic [3:0] reg_addr;
  logic [15:0] reg_wdata;
  logic [15:0] reg_rdata;
  logic [DATA_W-1:0] adc_data;
  logic adc_data_valid;
  logic busy;
  logic done;
  modport master (
    output adc_din, adc_din_valid, reg_wr_en, reg_addr, reg_wdata,
    input reg_rdata, adc_data, adc_data_valid, busy, done
  );
  modport slave (
    input adc_din, adc_din_valid, reg_wr_en, reg_addr, reg_wdata,
    output reg_rdata, adc_data, adc_data_valid, busy, done
  );
endinterface

// File: rtl/adc_capture_core.sv
// adc_capture_core: burst capture of ADC/ramp samples then packetised streaming; PKT_HEADER_EN adds a header word per packet
module adc_capture_core #(
  parameter int DATA_W = 18,
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input logic clk,
  input logic rst,
  adc_capture_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CAPTURE, PREAMBLE, SEND, GAP, DONE} state_t;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  state_t r_state, w_next;
  logic [2:0] r_ctrl, w_ctrl_nx;
  logic [7:0] r_gap, r_idle, r_pkt, r_s_gap, r_s_idle, r_s_pkt;
  logic [AW:0] r_cap, r_s_len, r_wr, r_rd;
  logic r_s_self, r_done, r_valid;
  logic [7:0] r_pcnt, r_cnt, r_pkts;
  logic [DATA_W-1:0] r_data, w_wdata, w_hdr_word;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic w_wr_ctrl, w_start, w_abort, w_store, w_cap_last, w_hdr, w_send, w_last, w_pend;
  assign w_wr_ctrl = bus.reg_wr_en && bus.reg_addr == 4'h0;
  assign w_ctrl_nx = w_wr_ctrl ? bus.reg_wdata[2:0] : r_ctrl;
  assign w_abort = !w_ctrl_nx[1];
  assign w_start = w_wr_ctrl && bus.reg_wdata[3] && w_ctrl_nx[1] && w_ctrl_nx[0] && r_state == IDLE;
  assign w_store = r_state == CAPTURE && (r_s_self || bus.adc_din_valid);
  assign w_cap_last = w_store && r_wr + 1'b1 == r_s_len;
  assign w_send = r_state == SEND && !w_hdr;
  assign w_last = w_send && r_rd + 1'b1 == r_s_len;
  assign w_pend = w_send && (w_last || r_pcnt + 8'd1 == r_s_pkt);
  assign w_wdata = r_s_self ? DATA_W'(r_wr) : bus.adc_din;
`ifdef PKT_HEADER_EN
  logic r_hdr;
  logic [AW:0] w_rem;
  logic [7:0] w_plen;
  assign w_hdr = r_hdr;
  assign w_rem = r_s_len - r_rd;
  assign w_plen = 8'(w_rem < (AW+1)'(r_s_pkt) ? w_rem : (AW+1)'(r_s_pkt));
  assign w_hdr_word = DATA_W'({2'b10, r_pkts, w_plen});
  always_ff @(posedge clk) begin
    if (rst || w_abort) r_hdr <= 1'b0;
    else if (r_state == IDLE) r_hdr <= w_start;
    else if (r_ctrl[0]) r_hdr <= w_pend ? 1'b1 : (r_state == SEND ? 1'b0 : r_hdr);
  end
`else
  assign w_hdr = 1'b0;
  assign w_hdr_word = '0;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = w_start ? CAPTURE : IDLE;
      CAPTURE: if (w_cap_last) w_next = r_s_idle == 8'd0 ? SEND : PREAMBLE;
      PREAMBLE: if (r_cnt + 8'd1 == r_s_idle) w_next = SEND;
      SEND: if (w_pend) w_next = w_last ? DONE : (r_s_gap == 8'd0 ? SEND : GAP);
      GAP: if (r_cnt + 8'd1 == r_s_gap) w_next = SEND;
      default: w_next = IDLE;
    endcase
    if (w_abort) w_next = IDLE;
    else if (!r_ctrl[0] && r_state != IDLE) w_next = r_state;
  end
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl <= '0;
      r_gap <= 8'd8;
      r_idle <= 8'd15;
      r_pkt <= 8'd16;
      r_cap <= FULL;
    end else if (bus.reg_wr_en) begin
      case (bus.reg_addr)
        4'h0: r_ctrl <= bus.reg_wdata[2:0];
        4'h1: r_gap <= bus.reg_wdata[7:0];
        4'h2: r_idle <= bus.reg_wdata[7:0];
        4'h3: r_pkt <= bus.reg_wdata[7:0];
        4'h4: r_cap <= bus.reg_wdata[AW:0];
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) if (r_ctrl[0] && !w_abort && w_store) r_mem[r_wr[AW-1:0]] <= w_wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      {r_s_gap, r_s_idle, r_s_pkt, r_s_len, r_s_self} <= '0;
      {r_wr, r_rd, r_pcnt, r_cnt, r_pkts} <= '0;
      r_done <= 1'b0;
      r_valid <= 1'b0;
      r_data <= '0;
    end else if (w_abort || r_state == IDLE) begin
      r_valid <= 1'b0;
      r_data <= '0;
      if (w_start) begin
        r_s_gap <= r_gap;
        r_s_idle <= r_idle;
        r_s_pkt <= r_pkt == 8'd0 ? 8'd1 : r_pkt;
        r_s_len <= (r_cap == '0 || r_cap > FULL) ? FULL : r_cap;
        r_s_self <= bus.reg_wdata[2];
        {r_wr, r_rd, r_pcnt, r_cnt, r_pkts} <= '0;
        r_done <= 1'b0;
      end
    end else if (r_ctrl[0]) begin
      r_cnt <= r_state != w_next ? 8'd0 : r_cnt + 8'd1;
      if (w_store) r_wr <= r_wr + 1'b1;
      if (w_send) r_rd <= r_rd + 1'b1;
      if (w_send) r_pcnt <= w_pend ? 8'd0 : r_pcnt + 8'd1;
      if (w_pend) r_pkts <= r_pkts + 8'd1;
      if (r_state == DONE) r_done <= 1'b1;
      r_valid <= r_state == SEND;
      r_data <= w_hdr ? w_hdr_word : (w_send ? r_mem[r_rd[AW-1:0]] : '0);
    end
  end
  assign bus.busy = r_state != IDLE;
  assign bus.done = r_done;
  assign bus.adc_data_valid = r_valid && r_ctrl[0];
  assign bus.adc_data = bus.adc_data_valid ? r_data : '0;
  always_comb begin
    bus.reg_rdata = 16'h0;
    case (bus.reg_addr)
      4'h0: bus.reg_rdata = {13'h0, r_ctrl};
      4'h1: bus.reg_rdata = {8'h0, r_gap};
      4'h2: bus.reg_rdata = {8'h0, r_idle};
      4'h3: bus.reg_rdata = {8'h0, r_pkt};
      4'h4: bus.reg_rdata = 16'(r_cap);
      4'h5: bus.reg_rdata = {r_pkts, 5'h0, r_ctrl[0], r_done, r_state != IDLE};
      default: ;
    endcase
  end
endmodule

// File: tb/tb_adc_capture_core.sv
// tb_adc_capture_core: table-driven register checks plus scoreboarded capture/stream scenarios
module tb_adc_capture_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [17:0] sb [$];
  adc_capture_if #(.DATA_W(18)) bus();
  adc_capture_core dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic wr;
    logic [3:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
    string name;
  } vec_t;
  vec_t vecs [13];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [17:0] hdr(input int idx, input int len);
    logic [7:0] i8, l8;
    i8 = idx[7:0];
    l8 = len[7:0];
    return {2'b10, i8, l8};
  endfunction
  task automatic push_ramp(input int len, input int pkt);
    for (int i = 0; i < len; i++) begin
`ifdef PKT_HEADER_EN
      if (i % pkt == 0) sb.push_back(hdr(i / pkt, (len - i < pkt) ? len - i : pkt));
`endif
      sb.push_back(18'(i));
    end
  endtask
  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    bus.reg_wr_en = 1'b1;
    bus.reg_addr = a;
    bus.reg_wdata = d;
    @(negedge clk);
    bus.reg_wr_en = 1'b0;
  endtask
  task automatic rd(input logic [3:0] a, input logic [15:0] exp, input string name);
    bus.reg_addr = a;
    #1;
    chk(name, bus.reg_rdata, exp);
  endtask
  task automatic wait_valid(input int exp, input string name);
    int n = 0;
    while (!bus.adc_data_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(name, n, exp);
  endtask
  task automatic run_len(input logic v, input int exp, input string name);
    int n = 0;
    while (bus.adc_data_valid == v && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(name, n, exp);
  endtask
  task automatic wait_done(input string name);
    int n = 0;
    while (!bus.done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(name, bus.done, 1);
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.adc_data_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra got=%0h want=none t=%0t", bus.adc_data, $time);
        end else chk("sb_data", bus.adc_data, sb.pop_front());
      end else chk("idle_zero", bus.adc_data, 0);
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end
  initial begin
    int hx;
`ifdef PKT_HEADER_EN
    hx = 1;
`else
    hx = 0;
`endif
    bus.adc_din = '0;
    bus.adc_din_valid = 1'b0;
    bus.reg_wr_en = 1'b0;
    bus.reg_addr = '0;
    bus.reg_wdata = '0;
    vecs[0] = '{1'b0, 4'h1, 16'h0, 16'd8, "gap_rst"};
    vecs[1] = '{1'b0, 4'h2, 16'h0, 16'd15, "idle_rst"};
    vecs[2] = '{1'b0, 4'h3, 16'h0, 16'd16, "pkt_rst"};
    vecs[3] = '{1'b0, 4'h4, 16'h0, 16'd256, "cap_rst"};
    vecs[4] = '{1'b0, 4'h0, 16'h0, 16'h0, "ctrl_rst"};
    vecs[5] = '{1'b0, 4'h5, 16'h0, 16'h0, "status_rst"};
    vecs[6] = '{1'b0, 4'h9, 16'h0, 16'h0, "unmapped"};
    vecs[7] = '{1'b1, 4'h1, 16'h01ff, 16'h00ff, "gap_wr"};
    vecs[8] = '{1'b1, 4'h4, 16'h0fff, 16'h01ff, "cap_wr"};
    vecs[9] = '{1'b1, 4'h0, 16'h0007, 16'h0007, "ctrl_wr"};
    vecs[10] = '{1'b1, 4'h0, 16'h0008, 16'h0000, "start_rd0"};
    vecs[11] = '{1'b1, 4'h5, 16'hffff, 16'h0000, "status_ro"};
    vecs[12] = '{1'b1, 4'h3, 16'h0000, 16'h0000, "pkt_wr0"};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", bus.adc_data_valid, 0);
    chk("rst_data", bus.adc_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    foreach (vecs[i]) begin
      @(negedge clk);
      if (vecs[i].wr) wr(vecs[i].addr, vecs[i].wdata);
      rd(vecs[i].addr, vecs[i].exp, vecs[i].name);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rd(4'h4, 16'd256, "cap_rerst");
    @(negedge clk);
    wr(4'h4, 16'd40);
    push_ramp(40, 16);
    wr(4'h0, 16'h000f);
    chk("busy_start", bus.busy, 1);
    wr(4'h0, 16'h000f);
    wait_valid(55, "preamble_lat");
    run_len(1'b1, 16 + hx, "burst0");
    run_len(1'b0, 8, "gap0");
    run_len(1'b1, 16 + hx, "burst1");
    run_len(1'b0, 8, "gap1");
    run_len(1'b1, 8 + hx, "burst2");
    chk("done_set", bus.done, 1);
    chk("busy_end", bus.busy, 0);
    rd(4'h5, 16'h0306, "status_pkts");
    chk("sb_empty2", sb.size(), 0);
    @(negedge clk);
    wr(4'h4, 16'd4);
`ifdef PKT_HEADER_EN
    sb.push_back(hdr(0, 4));
`endif
    for (int i = 0; i < 4; i++) sb.push_back(18'h100 + 18'(2 * i));
    wr(4'h0, 16'h000b);
    chk("done_clr", bus.done, 0);
    for (int i = 0; i < 8; i++) begin
      bus.adc_din = 18'h100 + 18'(i);
      bus.adc_din_valid = (i % 2 == 0);
      @(negedge clk);
    end
    bus.adc_din_valid = 1'b0;
    wait_done("done_norm");
    chk("sb_empty3", sb.size(), 0);
    wr(4'h1, 16'd0);
    wr(4'h3, 16'd1);
    wr(4'h4, 16'd5);
    push_ramp(5, 1);
    wr(4'h0, 16'h000f);
    wait_valid(21, "lat_b2b");
    run_len(1'b1, 5 + 5 * hx, "b2b_run");
    wait_done("done_b2b");
    chk("sb_empty4", sb.size(), 0);
    wr(4'h1, 16'd8);
    wr(4'h3, 16'd16);
    wr(4'h4, 16'd20);
    push_ramp(20, 16);
    wr(4'h0, 16'h000f);
    wait_valid(36, "lat_abort");
    repeat (4) @(negedge clk);
    wr(4'h0, 16'h0001);
    chk("abort_valid", bus.adc_data_valid, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    chk("abort_stay", bus.busy, 0);
    push_ramp(20, 16);
    wr(4'h0, 16'h000f);
    wait_valid(36, "lat_freeze");
    repeat (3) @(negedge clk);
    wr(4'h0, 16'h0002);
    begin
      int nv = 0;
      for (int i = 0; i < 10; i++) begin
        if (bus.adc_data_valid) nv++;
        @(negedge clk);
      end
      chk("frozen_valid", nv, 0);
      chk("frozen_busy", bus.busy, 1);
    end
    wr(4'h0, 16'h0003);
    wait_done("done_freeze");
    chk("sb_empty6", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
